// File: rtl/seq_lock_detector.sv
// Sequence-lock detector: steps through a DEPTH-symbol pattern one symbol per clock,
// counts wrong symbols, and locks out input for LOCK_CYCLES clocks after MAX_FAIL misses.
module seq_lock_detector #(
    parameter int                       SYM_W       = 2,
    parameter int                       DEPTH       = 5,
    parameter logic [DEPTH*SYM_W-1:0]   PATTERN     = 10'h16B,
    parameter logic [SYM_W-1:0]         IDLE_SYM    = '0,
    parameter bit                       STICKY      = 1'b1,
    parameter int                       MAX_FAIL    = 3,
    parameter int                       LOCK_CYCLES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [SYM_W-1:0]               sym,
    output logic                           led,
    output logic [$clog2(DEPTH+1)-1:0]     progress,
    output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt,
    output logic                           locked_out
);
    localparam int PW = $clog2(DEPTH+1);
    localparam int FW = $clog2(MAX_FAIL+1);
    localparam int TW = $clog2(LOCK_CYCLES+1);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        MATCHED = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t           state_reg;
    logic [PW-1:0]    progress_reg;
    logic [FW-1:0]    fail_cnt_reg;
    logic [TW-1:0]    timer_reg;
    logic             led_reg;
    logic             locked_out_reg;

    if (DEPTH < 1)       begin : g_bad_depth $error("DEPTH must be >= 1"); end
    if (MAX_FAIL < 1)    begin : g_bad_fail  $error("MAX_FAIL must be >= 1"); end
    if (LOCK_CYCLES < 1) begin : g_bad_lock  $error("LOCK_CYCLES must be >= 1"); end

    // Table padded to a power of two so progress_reg indexes it without a width mismatch.
    logic [SYM_W-1:0] pattern_sym [2**PW];

    genvar gi;
    generate
        for (gi = 0; gi < 2**PW; gi++) begin : g_pat
            if (gi < DEPTH) begin : g_real
                assign pattern_sym[gi] = PATTERN[gi*SYM_W +: SYM_W];
                if (PATTERN[gi*SYM_W +: SYM_W] == IDLE_SYM) begin : g_bad_idle
                    $error("IDLE_SYM must not occur in PATTERN");
                end
            end else begin : g_pad
                assign pattern_sym[gi] = IDLE_SYM;
            end
        end
    endgenerate

    logic [SYM_W-1:0] expected_sym;
    logic [FW-1:0]    fail_inc;

    assign expected_sym = pattern_sym[progress_reg];
    assign fail_inc     = fail_cnt_reg + FW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ARMED;
            progress_reg   <= '0;
            fail_cnt_reg   <= '0;
            timer_reg      <= '0;
            led_reg        <= 1'b0;
            locked_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                ARMED: begin
                    if (sym == IDLE_SYM) begin
                        state_reg <= ARMED;
                    end else if (sym == expected_sym) begin
                        if (progress_reg == PW'(DEPTH-1)) begin
                            state_reg    <= MATCHED;
                            led_reg      <= 1'b1;
                            progress_reg <= PW'(DEPTH);
                        end else begin
                            progress_reg <= progress_reg + PW'(1);
                        end
                    end else begin
                        fail_cnt_reg <= fail_inc;
                        // Lockout takes precedence over restarting on a first-symbol hit.
                        if (fail_inc == FW'(MAX_FAIL)) begin
                            state_reg      <= LOCKOUT;
                            progress_reg   <= '0;
                            locked_out_reg <= 1'b1;
                            timer_reg      <= TW'(LOCK_CYCLES);
                        end else if (sym == pattern_sym[0]) begin
                            progress_reg <= PW'(1);
                        end else begin
                            progress_reg <= '0;
                        end
                    end
                end
                MATCHED: begin
                    if (!STICKY) begin
                        state_reg    <= ARMED;
                        led_reg      <= 1'b0;
                        progress_reg <= '0;
                        fail_cnt_reg <= '0;
                    end
                end
                LOCKOUT: begin
                    timer_reg <= timer_reg - TW'(1);
                    if (timer_reg == TW'(1)) begin
                        state_reg      <= ARMED;
                        locked_out_reg <= 1'b0;
                        fail_cnt_reg   <= '0;
                        progress_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= ARMED;
                end
            endcase
        end
    end

    assign led        = led_reg;
    assign progress   = progress_reg;
    assign fail_cnt   = fail_cnt_reg;
    assign locked_out = locked_out_reg;

endmodule

// File: tb/tb_seq_lock_detector.sv
// Directed bench for seq_lock_detector: sticky instance for most scenarios,
// a pulse-mode instance for the re-arm behaviour.
module tb_seq_lock_detector;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sym = 2'b00;

    logic       led_s, locked_s;
    logic [2:0] prog_s;
    logic [1:0] fail_s;
    logic       led_p, locked_p;
    logic [2:0] prog_p;
    logic [1:0] fail_p;

    int checks = 0;
    int failures = 0;

    logic [1:0] pat [5];
    logic [1:0] gap_seq [7];
    int         gap_prog [7];
    logic [1:0] junk [4];

    always #5 clk = ~clk;

    seq_lock_detector #(.STICKY(1'b1)) dut (
        .clk(clk), .reset(reset), .sym(sym),
        .led(led_s), .progress(prog_s), .fail_cnt(fail_s), .locked_out(locked_s)
    );

    seq_lock_detector #(.STICKY(1'b0)) dut_p (
        .clk(clk), .reset(reset), .sym(sym),
        .led(led_p), .progress(prog_p), .fail_cnt(fail_p), .locked_out(locked_p)
    );

    task automatic step(input logic [1:0] s);
        sym = s;
        @(posedge clk);
        #1;
        $display("txn sym=%b rst=%b | sticky led=%b prog=%0d fail=%0d lock=%b | pulse led=%b prog=%0d fail=%0d lock=%b",
                 s, reset, led_s, prog_s, fail_s, locked_s, led_p, prog_p, fail_p, locked_p);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2'b00);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (led_s !== 1'b0 || prog_s !== 3'd0 || fail_s !== 2'd0 || locked_s !== 1'b0) begin
            failures++;
            $display("FAIL reset_state led=%b prog=%0d fail=%0d lock=%b required 0/0/0/0",
                     led_s, prog_s, fail_s, locked_s);
        end
    endtask

    task automatic test_sticky_match();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(pat[i]);
            checks++;
            if (prog_s !== 3'(i+1) || led_s !== (i == 4)) begin
                failures++;
                $display("FAIL sticky_step%0d prog=%0d led=%b required prog=%0d led=%b",
                         i, prog_s, led_s, i+1, (i == 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(junk[i]);
            checks++;
            if (led_s !== 1'b1 || prog_s !== 3'd5 || locked_s !== 1'b0) begin
                failures++;
                $display("FAIL sticky_hold%0d led=%b prog=%0d lock=%b required led=1 prog=5 lock=0",
                         i, led_s, prog_s, locked_s);
            end
        end
    endtask

    task automatic test_idle_gaps();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(gap_seq[i]);
            checks++;
            if (prog_s !== 3'(gap_prog[i]) || led_s !== (i == 6) || fail_s !== 2'd0) begin
                failures++;
                $display("FAIL idle_gap%0d prog=%0d led=%b fail=%0d required prog=%0d led=%b fail=0",
                         i, prog_s, led_s, fail_s, gap_prog[i], (i == 6));
            end
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        step(2'b11);
        step(2'b10);
        step(2'b01);
        checks++;
        if (fail_s !== 2'd1 || prog_s !== 3'd0) begin
            failures++;
            $display("FAIL mismatch_wrong3rd fail=%0d prog=%0d required fail=1 prog=0", fail_s, prog_s);
        end
        step(2'b11);
        checks++;
        if (fail_s !== 2'd1 || prog_s !== 3'd1) begin
            failures++;
            $display("FAIL mismatch_restart fail=%0d prog=%0d required fail=1 prog=1", fail_s, prog_s);
        end
        // C where B is expected: a mismatch that also restarts at progress 1
        step(2'b11);
        checks++;
        if (fail_s !== 2'd2 || prog_s !== 3'd1 || locked_s !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_first_sym fail=%0d prog=%0d lock=%b required fail=2 prog=1 lock=0",
                     fail_s, prog_s, locked_s);
        end
    endtask

    task automatic test_lockout();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(2'b01);
            checks++;
            if (fail_s !== 2'(i+1) || locked_s !== (i == 2) || prog_s !== 3'd0) begin
                failures++;
                $display("FAIL lockout_fail%0d fail=%0d lock=%b prog=%0d required fail=%0d lock=%b prog=0",
                         i, fail_s, locked_s, prog_s, i+1, (i == 2));
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(i < 5 ? pat[i] : 2'b00);
            checks++;
            if (locked_s !== (i < 7) || prog_s !== 3'd0 || led_s !== 1'b0) begin
                failures++;
                $display("FAIL lockout_cycle%0d lock=%b prog=%0d led=%b required lock=%b prog=0 led=0",
                         i, locked_s, prog_s, led_s, (i < 7));
            end
        end
        checks++;
        if (fail_s !== 2'd0) begin
            failures++;
            $display("FAIL lockout_exit_fail fail=%0d required 0", fail_s);
        end
        for (int i = 0; i < 5; i++) step(pat[i]);
        checks++;
        if (led_s !== 1'b1 || prog_s !== 3'd5) begin
            failures++;
            $display("FAIL lockout_then_match led=%b prog=%0d required led=1 prog=5", led_s, prog_s);
        end
    endtask

    task automatic test_pulse();
        do_reset();
        step(2'b01);
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 5; i++) step(pat[i]);
            checks++;
            if (led_p !== 1'b1 || prog_p !== 3'd5 || fail_p !== 2'(rep == 0 ? 1 : 0)) begin
                failures++;
                $display("FAIL pulse_hit%0d led=%b prog=%0d fail=%0d required led=1 prog=5 fail=%0d",
                         rep, led_p, prog_p, fail_p, (rep == 0 ? 1 : 0));
            end
            step(2'b11);
            checks++;
            if (led_p !== 1'b0 || prog_p !== 3'd0 || fail_p !== 2'd0) begin
                failures++;
                $display("FAIL pulse_rearm%0d led=%b prog=%0d fail=%0d required 0/0/0",
                         rep, led_p, prog_p, fail_p);
            end
        end
        checks++;
        if (led_s !== 1'b1 || fail_s !== 2'd1) begin
            failures++;
            $display("FAIL sticky_keeps_fail led=%b fail=%0d required led=1 fail=1", led_s, fail_s);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) step(pat[i]);
        reset = 1'b1;
        step(2'b10);
        reset = 1'b0;
        checks++;
        if (prog_s !== 3'd0 || led_s !== 1'b0 || fail_s !== 2'd0 || locked_s !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_seq prog=%0d led=%b fail=%0d lock=%b required all 0",
                     prog_s, led_s, fail_s, locked_s);
        end
        for (int i = 0; i < 3; i++) step(2'b01);
        for (int i = 0; i < 3; i++) step(2'b00);
        reset = 1'b1;
        step(2'b00);
        reset = 1'b0;
        checks++;
        if (prog_s !== 3'd0 || led_s !== 1'b0 || fail_s !== 2'd0 || locked_s !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_lockout prog=%0d led=%b fail=%0d lock=%b required all 0",
                     prog_s, led_s, fail_s, locked_s);
        end
        for (int i = 0; i < 5; i++) step(pat[i]);
        reset = 1'b1;
        step(2'b00);
        reset = 1'b0;
        checks++;
        if (prog_s !== 3'd0 || led_s !== 1'b0 || fail_s !== 2'd0 || locked_s !== 1'b0) begin
            failures++;
            $display("FAIL reset_matched prog=%0d led=%b fail=%0d lock=%b required all 0",
                     prog_s, led_s, fail_s, locked_s);
        end
    endtask

    initial begin
        pat      = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01};
        gap_seq  = '{2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01};
        gap_prog = '{1, 2, 2, 2, 3, 4, 5};
        junk     = '{2'b01, 2'b10, 2'b11, 2'b00};
        test_reset();
        test_sticky_match();
        test_idle_gaps();
        test_mismatch();
        test_lockout();
        test_pulse();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
